mem_stage_hs: RTL
=================

// Module: mem_stage_hs
// PURPOSE
//   Next-generation MIPS pipeline memory stage. Sits between EX/MEM and MEM/WB.
//   Adds over the previous stage:
//   - a req/ack data-memory port with arbitrary wait states, stalling upstream;
//   - byte/halfword/word sub-word access with sign/zero extension;
//   - a valid-qualified MEM/WB bundle.
//   Writeback select (LUOp, MemToReg) is unchanged.
// PARAMETERS
//   DATA_W      32  datapath width; 32 or 64 only (64 enables size 2'b11 = dword)
//   ADDR_W      32  byte-address width
//   REG_ADDR_W  5   register-file index width
// PORTS
//   clk              in   1           single clock, rising edge
//   reset_b          in   1           asynchronous, active-low reset
//   in_valid         in   1           EX/MEM holds a valid instruction
//   in_ready         out  1           stage accepts in_valid this cycle (low = stall)
//   alu_s            in   ADDR_W      ALU result / memory byte address
//   mem_write_data   in   DATA_W      store data, right-justified
//   mem_read         in   1           load
//   mem_write        in   1           store (mem_read & mem_write = illegal, treated as load)
//   mem_size         in   2           00 byte, 01 half, 10 word, 11 dword (DATA_W=64)
//   mem_unsigned     in   1           zero-extend loads when 1, else sign-extend
//   write_reg        in   REG_ADDR_W  destination register
//   reg_write        in   1           writeback enable
//   mem_to_reg       in   2           00 ALU, 01 load, 10 PC+4, 11 PC+4-4 (exception)
//   pc_plus4         in   ADDR_W      PC+4 of instruction
//   lu_op            in   1           select lu_data, overrides mem_to_reg
//   lu_data          in   DATA_W      LUI data
//   dm_req           out  1           memory request, held until dm_ack
//   dm_we            out  1           write request
//   dm_addr          out  ADDR_W      lane-aligned address, low LANE_BITS forced 0
//   dm_be            out  DATA_W/8    byte enables
//   dm_wdata         out  DATA_W      lane-replicated store data
//   dm_ack           in   1           completes request; honoured only in BUSY
//   dm_rdata         in   DATA_W      read data, valid with dm_ack
//   mem_wb_valid     out  1           MEM/WB bundle valid
//   mem_wb_data      out  DATA_W      writeback data
//   mem_wb_reg       out  REG_ADDR_W  writeback index
//   mem_wb_regwrite  out  1           writeback enable, qualified by mem_wb_valid
// BEHAVIOUR
//   Reset: state IDLE; all outputs 0; in_ready is 1 once reset_b deasserts.
//   FSM IDLE/BUSY. in_ready = (state==IDLE).
//   IDLE, in_valid, no mem op:
//     - MEM/WB loaded at next edge (1-cycle latency);
//     - mem_wb_valid=1 for exactly one cycle unless another valid follows.
//   IDLE, in_valid, load/store:
//     - latch request; next edge -> BUSY;
//     - dm_req/dm_we/dm_addr/dm_be/dm_wdata registered and held stable while BUSY.
//   BUSY, dm_ack=1:
//     - loads: extract lane, then extend;
//     - MEM/WB written, mem_wb_valid=1 for 1 cycle;
//     - dm_req drops; return to IDLE.
//   Timing: ack in first BUSY cycle is legal. Min load/store latency = 2 cycles;
//     each wait state adds 1.
//   BUSY, dm_ack=0: no MEM/WB update, mem_wb_valid=0.
//   Idle cycle: mem_wb_valid=0, other MEM/WB fields hold.
//   LANE_BITS=log2(DATA_W/8); lane index = alu_s[LANE_BITS-1:0] truncated to size.
//   dm_be per size:
//     - byte: 1<<idx;
//     - half: 2'b11<<(idx&~1);
//     - word: 4'hF<<(idx&~3);
//     - dword: all ones.
//   Misalignment (no macro): low address bits below the size are ignored.
//   Writeback data:
//     - lu_op ? lu_data : mux(mem_to_reg);
//     - 11 -> pc_plus4-4 (modulo 2^ADDR_W);
//     - PC values zero-extended to DATA_W.
//   Reset mid-BUSY: abandon access, dm_req=0 asynchronously. A stale dm_ack
//     arriving after reset in IDLE is ignored.
//   Stores: mem_wb_regwrite follows reg_write (normally 0).
// CONFIGURATION
//   MEM_STAGE_ALIGN_EXC_EN defined:
//     - adds ports exc_valid (out 1), exc_addr (out ADDR_W) and exc_store (out 1);
//     - a misaligned load/store issues no dm_req and stays in IDLE;
//     - next edge: mem_wb_valid=1 with mem_wb_regwrite=0;
//     - exc_valid pulses 1 cycle with exc_addr=alu_s and exc_store=mem_write;
//     - exc_* reset to 0.
//   MEM_STAGE_ALIGN_EXC_EN undefined: no exc ports; misaligned access treated as
//     aligned (BEHAVIOUR).
// STRUCTURE
//   Package mem_stage_pkg holds:
//     - SIZE_BYTE/HALF/WORD/DWORD;
//     - WB_ALU/WB_LOAD/WB_PC4/WB_EXC;
//     - state enum IDLE/BUSY;
//     - function lane_bits(DATA_W).
//   Sub-module mem_lane_align (combinational):
//     - store side: size+offset -> be, replicated wdata;
//     - load side: rdata+size+offset+unsigned -> extended load.
//   FSM and MEM/WB register stay in the top.
// TESTING
//   1. ALU op, alu_s=0x1234, mem_to_reg=00, write_reg=5 -> next cycle mem_wb_valid=1,
//      data=0x1234, reg=5.
//   2. LW addr 0x100, dm_ack after 3 wait cycles, rdata 0xDEADBEEF ->
//      - in_ready low 4 cycles;
//      - data=0xDEADBEEF, valid 1 cycle.
//   3. LB signed addr 0x103, rdata 0x80000000 -> data=0xFFFFFF80;
//      LBU -> 0x00000080.
//   4. SH addr 0x102, data 0xABCD -> dm_be=4'b1100, dm_wdata=0xABCDABCD, dm_we=1.
//   5. reset_b low during BUSY, then dm_ack pulse -> dm_req=0, no mem_wb_valid,
//      in_ready=1.
//   6. MEM_STAGE_ALIGN_EXC_EN: LW addr 0x102 ->
//      - no dm_req;
//      - exc_valid=1, exc_addr=0x102, exc_store=0;
//      - mem_wb_regwrite=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants, state type and helpers for the MIPS memory stage.
package mem_stage_pkg;

   localparam logic [1:0] SIZE_BYTE  = 2'b00;
   localparam logic [1:0] SIZE_HALF  = 2'b01;
   localparam logic [1:0] SIZE_WORD  = 2'b10;
   localparam logic [1:0] SIZE_DWORD = 2'b11;

   localparam logic [1:0] WB_ALU  = 2'b00;
   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] WB_EXC  = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // Number of byte-offset bits inside one datapath lane.
   function automatic int lane_bits(input int dataW);
      return $clog2(dataW / 8);
   endfunction

   // Address bits that must be zero for a naturally aligned access of this size.
   // On a 32-bit datapath size 11 behaves as a full-width (word) access.
   function automatic logic [2:0] size_mask(input logic [1:0] size, input int dataW);
      logic [2:0] mask;
      case (size)
         SIZE_BYTE: mask = 3'b000;
         SIZE_HALF: mask = 3'b001;
         SIZE_WORD: mask = 3'b011;
         default:   mask = (dataW == 64) ? 3'b111 : 3'b011;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Sub-word lane steering: byte enables and replicated store data on the way
// out, lane extraction and sign/zero extension on the way back.
module mem_lane_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32,
   localparam int LB    = lane_bits(DATA_W),
   localparam int BE_W  = DATA_W / 8
) (
   input  logic [1:0]        stSize,
   input  logic [LB-1:0]     stOffset,
   input  logic [DATA_W-1:0] stData,
   output logic [BE_W-1:0]   be,
   output logic [DATA_W-1:0] wdata,
   input  logic [1:0]        ldSize,
   input  logic [LB-1:0]     ldOffset,
   input  logic              ldUnsigned,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] loadData
);

   logic [LB-1:0]     stIdxS;
   logic [LB-1:0]     ldIdxS;
   logic [DATA_W-1:0] shiftedS;

   // Store side: drop offset bits below the access size, then place the lane mask.
   always_comb begin
      stIdxS = stOffset & ~(LB'(size_mask(stSize, DATA_W)));
      be     = '0;
      wdata  = '0;
      case (stSize)
         SIZE_BYTE: begin
            be    = BE_W'(1'b1) << stIdxS;
            wdata = {BE_W{stData[7:0]}};
         end
         SIZE_HALF: begin
            be    = BE_W'(2'b11) << stIdxS;
            wdata = {(DATA_W/16){stData[15:0]}};
         end
         SIZE_WORD: begin
            be    = BE_W'(4'hF) << stIdxS;
            wdata = {(DATA_W/32){stData[31:0]}};
         end
         default: begin
            be    = '1;
            wdata = stData;
         end
      endcase
   end

   // Load side: shift the addressed lane down to bit 0, then extend it.
   always_comb begin
      ldIdxS   = ldOffset & ~(LB'(size_mask(ldSize, DATA_W)));
      shiftedS = rdata >> {ldIdxS, 3'b000};
      loadData = '0;
      case (ldSize)
         SIZE_BYTE: begin
            if (ldUnsigned) loadData = DATA_W'(shiftedS[7:0]);
            else            loadData = DATA_W'($signed(shiftedS[7:0]));
         end
         SIZE_HALF: begin
            if (ldUnsigned) loadData = DATA_W'(shiftedS[15:0]);
            else            loadData = DATA_W'($signed(shiftedS[15:0]));
         end
         SIZE_WORD: begin
            if (ldUnsigned) loadData = DATA_W'(shiftedS[31:0]);
            else            loadData = DATA_W'($signed(shiftedS[31:0]));
         end
         default: loadData = shiftedS;
      endcase
   end

endmodule

// File: rtl/mem_stage_hs.sv
// MIPS memory stage with req/ack data-memory handshake, sub-word accesses and a
// valid-qualified MEM/WB bundle. Define MEM_STAGE_ALIGN_EXC_EN to raise an
// alignment exception (exc_* ports) instead of silently aligning accesses.
module mem_stage_hs
   import mem_stage_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset_b,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_W-1:0]     alu_s,
   input  logic [DATA_W-1:0]     mem_write_data,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [1:0]            mem_size,
   input  logic                  mem_unsigned,
   input  logic [REG_ADDR_W-1:0] write_reg,
   input  logic                  reg_write,
   input  logic [1:0]            mem_to_reg,
   input  logic [ADDR_W-1:0]     pc_plus4,
   input  logic                  lu_op,
   input  logic [DATA_W-1:0]     lu_data,
   output logic                  dm_req,
   output logic                  dm_we,
   output logic [ADDR_W-1:0]     dm_addr,
   output logic [DATA_W/8-1:0]   dm_be,
   output logic [DATA_W-1:0]     dm_wdata,
   input  logic                  dm_ack,
   input  logic [DATA_W-1:0]     dm_rdata,
   output logic                  mem_wb_valid,
   output logic [DATA_W-1:0]     mem_wb_data,
   output logic [REG_ADDR_W-1:0] mem_wb_reg,
   output logic                  mem_wb_regwrite
`ifdef MEM_STAGE_ALIGN_EXC_EN
   ,
   output logic                  exc_valid,
   output logic [ADDR_W-1:0]     exc_addr,
   output logic                  exc_store
`endif
);

   localparam int LB   = lane_bits(DATA_W);
   localparam int BE_W = DATA_W / 8;

   state_t                stateR;
   logic [1:0]            ldSizeR;
   logic [LB-1:0]         ldOffsetR;
   logic                  ldUnsignedR;
   logic [REG_ADDR_W-1:0] regR;
   logic                  regWriteR;
   logic                  useLoadR;
   logic [DATA_W-1:0]     wbDataR;

   logic                  memOpS;
   logic                  misalignS;
   logic [BE_W-1:0]       beS;
   logic [DATA_W-1:0]     wdataS;
   logic [DATA_W-1:0]     loadDataS;
   logic [DATA_W-1:0]     wbNowS;

   // Writeback mux; the load value is supplied separately because it only
   // exists once the memory answers.
   function automatic logic [DATA_W-1:0] wb_select(
      input logic              luOp,
      input logic [DATA_W-1:0] luData,
      input logic [1:0]        mtr,
      input logic [ADDR_W-1:0] alu,
      input logic [ADDR_W-1:0] pc4,
      input logic [DATA_W-1:0] loadVal
   );
      logic [DATA_W-1:0] res;
      if (luOp) begin
         res = luData;
      end else begin
         case (mtr)
            WB_ALU:  res = DATA_W'(alu);
            WB_LOAD: res = loadVal;
            WB_PC4:  res = DATA_W'(pc4);
            default: res = DATA_W'(pc4 - ADDR_W'(3'd4));
         endcase
      end
      return res;
   endfunction

   assign memOpS   = mem_read | mem_write;
   assign in_ready = (stateR == IDLE);
   assign wbNowS   = wb_select(lu_op, lu_data, mem_to_reg, alu_s, pc_plus4, '0);

`ifdef MEM_STAGE_ALIGN_EXC_EN
   assign misalignS = memOpS && ((alu_s[2:0] & size_mask(mem_size, DATA_W)) != 3'b000);
`else
   assign misalignS = 1'b0;
`endif

   mem_lane_align #(.DATA_W(DATA_W)) uLane (
      .stSize     (mem_size),
      .stOffset   (alu_s[LB-1:0]),
      .stData     (mem_write_data),
      .be         (beS),
      .wdata      (wdataS),
      .ldSize     (ldSizeR),
      .ldOffset   (ldOffsetR),
      .ldUnsigned (ldUnsignedR),
      .rdata      (dm_rdata),
      .loadData   (loadDataS)
   );

   // Handshake FSM plus MEM/WB register: accept in IDLE, hold the request in BUSY.
   always_ff @(posedge clk or negedge reset_b) begin
      if (!reset_b) begin
         stateR          <= IDLE;
         dm_req          <= 1'b0;
         dm_we           <= 1'b0;
         dm_addr         <= '0;
         dm_be           <= '0;
         dm_wdata        <= '0;
         ldSizeR         <= 2'b00;
         ldOffsetR       <= '0;
         ldUnsignedR     <= 1'b0;
         regR            <= '0;
         regWriteR       <= 1'b0;
         useLoadR        <= 1'b0;
         wbDataR         <= '0;
         mem_wb_valid    <= 1'b0;
         mem_wb_data     <= '0;
         mem_wb_reg      <= '0;
         mem_wb_regwrite <= 1'b0;
`ifdef MEM_STAGE_ALIGN_EXC_EN
         exc_valid       <= 1'b0;
         exc_addr        <= '0;
         exc_store       <= 1'b0;
`endif
      end else begin
         mem_wb_valid <= 1'b0;
`ifdef MEM_STAGE_ALIGN_EXC_EN
         exc_valid    <= 1'b0;
`endif
         case (stateR)
            IDLE: begin
               if (in_valid) begin
                  if (memOpS && !misalignS) begin
                     // mem_read wins when both are set, so the access is a load.
                     stateR      <= BUSY;
                     dm_req      <= 1'b1;
                     dm_we       <= ~mem_read;
                     dm_addr     <= {alu_s[ADDR_W-1:LB], {LB{1'b0}}};
                     dm_be       <= beS;
                     dm_wdata    <= wdataS;
                     ldSizeR     <= mem_size;
                     ldOffsetR   <= alu_s[LB-1:0];
                     ldUnsignedR <= mem_unsigned;
                     regR        <= write_reg;
                     regWriteR   <= reg_write;
                     wbDataR     <= wbNowS;
                     useLoadR    <= mem_read && !lu_op && (mem_to_reg == WB_LOAD);
                  end else begin
                     mem_wb_valid    <= 1'b1;
                     mem_wb_data     <= wbNowS;
                     mem_wb_reg      <= write_reg;
                     mem_wb_regwrite <= reg_write && !misalignS;
`ifdef MEM_STAGE_ALIGN_EXC_EN
                     exc_valid       <= misalignS;
                     if (misalignS) begin
                        exc_addr  <= alu_s;
                        exc_store <= mem_write && !mem_read;
                     end
`endif
                  end
               end
            end
            BUSY: begin
               if (dm_ack) begin
                  stateR          <= IDLE;
                  dm_req          <= 1'b0;
                  dm_we           <= 1'b0;
                  mem_wb_valid    <= 1'b1;
                  mem_wb_data     <= useLoadR ? loadDataS : wbDataR;
                  mem_wb_reg      <= regR;
                  mem_wb_regwrite <= regWriteR;
               end
            end
            default: begin
               stateR <= IDLE;
               dm_req <= 1'b0;
               dm_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule
